// File: rtl/store_align_unit_if.sv
// Store request / data-memory write bundle for the store alignment unit.
// slave = the unit itself, master = pipeline + memory side.
interface store_align_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        busy;
  logic        done;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask,
    output busy, done
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask,
    input  busy, done
  );
endinterface

// File: rtl/store_align_unit.sv
// Store byte-lane placement and write-mask generation; splits
// word-crossing stores into two memory beats.
module store_align_unit (
  input logic clk,
  input logic reset,
  store_align_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_e;

  state_e      state_q;
  logic        valid_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] b2_addr_q;
  logic [31:0] b2_wdata_q;
  logic [3:0]  b2_wmask_q;
  logic        split_q;

  logic [3:0]  nmask;
  logic [31:0] dmask;
  logic [63:0] lane_data;
  logic [7:0]  lane_mask;
  logic        last_beat;

  always_comb begin
    nmask = 4'b1111;
    dmask = 32'hFFFF_FFFF;
    unique case (bus.req_size)
      2'd0: begin
        nmask = 4'b0001;
        dmask = 32'h0000_00FF;
      end
      2'd1: begin
        nmask = 4'b0011;
        dmask = 32'h0000_FFFF;
      end
      default: begin
        nmask = 4'b1111;
        dmask = 32'hFFFF_FFFF;
      end
    endcase
  end

  // Shift into an 8-lane window; upper half is the second word's lanes.
  assign lane_data = {32'b0, bus.req_data & dmask}
                     << {bus.req_addr[1:0], 3'b000};
  assign lane_mask = {4'b0, nmask} << bus.req_addr[1:0];

  assign bus.req_ready = (state_q == IDLE) & ~reset;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_valid = valid_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;

  assign last_beat = (state_q == BEAT2) | ~split_q;
  assign bus.done  = valid_q & bus.mem_ready & last_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      b2_addr_q  <= '0;
      b2_wdata_q <= '0;
      b2_wmask_q <= '0;
      split_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            state_q    <= BEAT1;
            valid_q    <= 1'b1;
            addr_q     <= {bus.req_addr[31:2], 2'b00};
            wdata_q    <= lane_data[31:0];
            wmask_q    <= lane_mask[3:0];
            b2_addr_q  <= {bus.req_addr[31:2] + 30'd1, 2'b00};
            b2_wdata_q <= lane_data[63:32];
            b2_wmask_q <= lane_mask[7:4];
            split_q    <= |lane_mask[7:4];
          end
        end
        BEAT1: begin
          if (bus.mem_ready) begin
            if (split_q) begin
              state_q <= BEAT2;
              addr_q  <= b2_addr_q;
              wdata_q <= b2_wdata_q;
              wmask_q <= b2_wmask_q;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              addr_q  <= '0;
              wdata_q <= '0;
              wmask_q <= '0;
            end
          end
        end
        BEAT2: begin
          if (bus.mem_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: lane placement, splits,
// stalls, address wrap and asynchronous reset.
module tb_store_align_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  store_align_unit_if bus ();

  store_align_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {mem_valid, mem_addr, mem_wdata, mem_wmask, done, busy, req_ready}
  logic [71:0] obs;
  logic [71:0] exp_v;
  assign obs = {bus.mem_valid, bus.mem_addr, bus.mem_wdata,
                bus.mem_wmask, bus.done, bus.busy, bus.req_ready};

  localparam logic [71:0] IDLE_V = {1'b0, 32'h0, 32'h0, 4'h0,
                                    1'b0, 1'b0, 1'b1};
  localparam logic [71:0] ZERO_V = '0;

  task automatic cyc(input logic rv, input logic mr);
    @(negedge clk);
    bus.req_valid = rv;
    bus.mem_ready = mr;
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s, input logic mr);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = s;
    bus.mem_ready = mr;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1);
      total++;
      if (obs !== ZERO_V) begin
        bad++;
        $display("FAIL rst_hold got=%h want=%h", obs, ZERO_V);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    cyc(1'b0, 1'b0);
    total++;
    if (obs !== IDLE_V) begin
      bad++;
      $display("FAIL rst_release got=%h want=%h", obs, IDLE_V);
    end
  endtask

  task automatic test_sb;
    req(32'h0000_1003, 32'h1234_56AB, 2'd0, 1'b1);
    cyc(1'b0, 1'b1);
    exp_v = {1'b1, 32'h0000_1000, 32'hAB00_0000, 4'b1000,
             1'b1, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL sb_beat got=%h want=%h", obs, exp_v);
    end
    cyc(1'b0, 1'b1);
    total++;
    if (obs !== IDLE_V) begin
      bad++;
      $display("FAIL sb_idle got=%h want=%h", obs, IDLE_V);
    end
  endtask

  task automatic test_sh_split;
    req(32'h0000_2003, 32'h0000_BEEF, 2'd1, 1'b1);
    cyc(1'b0, 1'b1);
    exp_v = {1'b1, 32'h0000_2000, 32'hEF00_0000, 4'b1000,
             1'b0, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL sh_b1 got=%h want=%h", obs, exp_v);
    end
    cyc(1'b0, 1'b1);
    exp_v = {1'b1, 32'h0000_2004, 32'h0000_00BE, 4'b0001,
             1'b1, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL sh_b2 got=%h want=%h", obs, exp_v);
    end
    cyc(1'b0, 1'b1);
    total++;
    if (obs !== IDLE_V) begin
      bad++;
      $display("FAIL sh_idle got=%h want=%h", obs, IDLE_V);
    end
  endtask

  task automatic test_sw_stall;
    req(32'h0000_3002, 32'h1122_3344, 2'd2, 1'b0);
    exp_v = {1'b1, 32'h0000_3000, 32'h3344_0000, 4'b1100,
             1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, i == 3);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL sw_b1_c%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, i == 3);
      exp_v = {1'b1, 32'h0000_3004, 32'h0000_1122, 4'b0011,
               i == 3, 1'b1, 1'b0};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL sw_b2_c%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    cyc(1'b0, 1'b0);
    total++;
    if (obs !== IDLE_V) begin
      bad++;
      $display("FAIL sw_idle got=%h want=%h", obs, IDLE_V);
    end
  endtask

  task automatic test_wrap;
    req(32'hFFFF_FFFE, 32'hA1B2_C3D4, 2'd3, 1'b1);
    cyc(1'b0, 1'b1);
    exp_v = {1'b1, 32'hFFFF_FFFC, 32'hC3D4_0000, 4'b1100,
             1'b0, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL wrap_b1 got=%h want=%h", obs, exp_v);
    end
    cyc(1'b0, 1'b1);
    exp_v = {1'b1, 32'h0000_0000, 32'h0000_A1B2, 4'b0011,
             1'b1, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL wrap_b2 got=%h want=%h", obs, exp_v);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    req(32'h0000_5001, 32'hFFFF_0077, 2'd0, 1'b1);
    cyc(1'b1, 1'b1);
    bus.req_addr = 32'h0000_5006;
    bus.req_data = 32'hFFFF_9988;
    bus.req_size = 2'd1;
    exp_v = {1'b1, 32'h0000_5000, 32'h0000_7700, 4'b0010,
             1'b1, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL b2b_first got=%h want=%h", obs, exp_v);
    end
    cyc(1'b1, 1'b1);
    total++;
    if (obs !== IDLE_V) begin
      bad++;
      $display("FAIL b2b_gap got=%h want=%h", obs, IDLE_V);
    end
    cyc(1'b0, 1'b1);
    exp_v = {1'b1, 32'h0000_5004, 32'h9988_0000, 4'b1100,
             1'b1, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL b2b_second got=%h want=%h", obs, exp_v);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    req(32'h0000_6003, 32'h0000_1234, 2'd1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    exp_v = {1'b1, 32'h0000_6004, 32'h0000_0012, 4'b0001,
             1'b0, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL rm_b2_wait got=%h want=%h", obs, exp_v);
    end
    #1;
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if (obs !== ZERO_V) begin
      bad++;
      $display("FAIL rm_async got=%h want=%h", obs, ZERO_V);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1);
      total++;
      if (obs !== ZERO_V) begin
        bad++;
        $display("FAIL rm_hold%0d got=%h want=%h", i, obs, ZERO_V);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b1);
    total++;
    if (obs !== IDLE_V) begin
      bad++;
      $display("FAIL rm_noreissue got=%h want=%h", obs, IDLE_V);
    end
    req(32'h0000_4000, 32'hCAFE_F00D, 2'd2, 1'b1);
    cyc(1'b0, 1'b1);
    exp_v = {1'b1, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111,
             1'b1, 1'b1, 1'b0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL rm_sw got=%h want=%h", obs, exp_v);
    end
    cyc(1'b0, 1'b0);
    total++;
    if (obs !== IDLE_V) begin
      bad++;
      $display("FAIL rm_idle got=%h want=%h", obs, IDLE_V);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = '0;
    bus.mem_ready = 1'b0;
    test_reset;
    test_sb;
    test_sh_split;
    test_sw_stall;
    test_wrap;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end
endmodule

// File: doc/store_align_unit.md
# store_align_unit

Store-path counterpart of the load byte-extraction logic. It takes a right-aligned store value, a byte address and an access size from the MEM stage. It places the bytes onto the correct lanes of the 32-bit data-memory word and generates the per-byte write mask. A store that crosses a word boundary is split into two memory write beats under a valid/ready handshake, and the pipeline is stalled until the store completes.

## Interface
Parameters:
- none (datapath fixed at 32-bit words, 4 byte lanes)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request
- req_addr  in  32  byte address of first byte stored
- req_data  in  32  store value, right-aligned (byte 0 = bits 7:0)
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = treated as word
- mem_valid  out  1  write beat presented to data memory
- mem_ready  in  1  memory accepts current beat
- mem_addr  out  32  word-aligned address (bits 1:0 always 0)
- mem_wdata  out  32  lane-placed write data; disabled lanes driven 0
- mem_wmask  out  4  byte enable; bit k enables mem_wdata[8k+7:8k]
- busy  out  1  stall to pipeline; high whenever state is not IDLE
- done  out  1  one-cycle pulse on the final beat's handshake

## Operation
- n = 1/2/4 bytes from req_size; off = req_addr[1:0].
- Source byte i (i < n) is written to absolute byte address req_addr + i.
- Beat 1:
  - mem_addr = {req_addr[31:2], 2'b00}
  - lanes off .. min(3, off+n-1)
- Split condition: off + n > 4.
- Beat 2 (split only):
  - mem_addr = beat-1 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000)
  - lanes 0 .. off+n-5
- Both beats' addr/wdata/wmask are computed and registered at request acceptance. No datapath input is sampled after acceptance.
- FSM states: IDLE, BEAT1, BEAT2.
  - IDLE: req_ready = 1 (0 while reset is asserted). On req_valid & req_ready, capture the request and go to BEAT1.
  - BEAT1: mem_valid = 1 with beat-1 fields. On mem_ready, go to BEAT2 if split, else go to IDLE.
  - BEAT2: mem_valid = 1 with beat-2 fields. On mem_ready, go to IDLE.
- done = mem_valid & mem_ready & (final beat). It is combinational from state and mem_ready.
- busy = (state != IDLE).
- While mem_valid & !mem_ready, mem_addr/mem_wdata/mem_wmask are held stable.
- mem_wmask is never 0 while mem_valid = 1.
- req_data bits above byte n-1 are ignored.

## Timing
- Reset values: state IDLE, mem_valid 0, mem_addr 0, mem_wdata 0, mem_wmask 0, done 0, busy 0. req_ready is 0 during reset and 1 on the first cycle after release.
- Reset mid-operation: state is forced to IDLE immediately (asynchronous) and mem_valid drops. No done pulse is issued and the aborted beat(s) are not reissued.
- Acceptance in cycle t:
  - mem_valid rises in cycle t+1.
  - With mem_ready constantly high, an unsplit store completes (done) in t+1 and a split store in t+2.
  - req_ready returns in the cycle after done.
- No request overlap: maximum throughput is one unsplit store per 2 cycles, one split store per 3 cycles.
- Outside BEAT1/BEAT2, mem_addr/wdata/wmask return to 0.
- A mem_ready asserted while mem_valid = 0 has no effect.
- A req_valid arriving while busy is ignored and must be held by the requester.

## Test plan
- Reset: assert reset for 3 cycles mid-stream, then release.
  - Required: all outputs 0 during reset; req_ready = 1 the cycle after release.
- sb, addr 0x00001003, data 0x123456AB, mem_ready = 1.
  - Required: one beat with mem_addr 0x00001000, wdata 0xAB000000, wmask 4'b1000.
  - done is high in the same cycle as the beat; busy falls the next cycle.
- sh, addr 0x00002003, data 0x0000BEEF (split).
  - Beat 1: 0x00002000, 0xEF000000, mask 4'b1000.
  - Beat 2: 0x00002004, 0x000000BE, mask 4'b0001.
  - done only on beat 2.
- sw, addr 0x00003002, data 0x11223344, mem_ready low 3 cycles per beat.
  - Beat 1: 0x00003000, 0x33440000, mask 4'b1100, held stable while stalled.
  - Beat 2: 0x00003004, 0x00001122, mask 4'b0011.
- sw, addr 0xFFFFFFFE, data 0xA1B2C3D4.
  - Beat 1: 0xFFFFFFFC, 0xC3D40000, mask 4'b1100.
  - Beat 2: 0x00000000, 0x0000A1B2, mask 4'b0011.
- Split sh with reset asserted while BEAT2 waits on mem_ready = 0.
  - Required: mem_valid drops immediately; no done.
  - After release, an aligned sw to 0x00004000 with data 0xCAFEF00D writes wdata 0xCAFEF00D, mask 4'b1111.
